// File: rtl/cam_capture_axis_if.sv
// AXI4-Stream video beat bundle between the camera front end and the VDMA S2MM port.
interface cam_capture_axis_if;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic [31:0] tdata;

  modport master (output tvalid, output tlast, output tuser, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tuser, input tdata, output tready);
endinterface

// File: rtl/cam_capture_axis.sv
// DVP camera capture to AXI4-Stream: byte pairing, frame/line bounding, FWFT output FIFO.
// Define CAM_CAPTURE_STATS_EN to build the frame and short-line counters.
//
// state   | meaning
// WAIT_VS | after reset; bus ignored until the first vsync fall
// CAPTURE | in-bounds pixels are pushed into the FIFO
// DROP    | a pixel was lost to a full FIFO; discard until the next vsync fall
module cam_capture_axis #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int OUT_FMT    = 0
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                href,
  input  logic                vsync,
  input  logic [7:0]          data,
  cam_capture_axis_if.master  m_axis,
  output logic                overflow,
  output logic                frame_active,
  output logic [15:0]         frame_count,
  output logic [15:0]         line_err_count
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [11:0] H_LIM  = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    CAPTURE = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vsync_q, href_q, phase_q;
  logic [7:0]  hi_q;
  logic [11:0] col_q, row_q;

  logic        vs_fall, bus_on, pix_done, href_fall, in_bounds;
  logic        push, pop, ovf_set, full, empty;
  logic [15:0] pixel;
  logic [31:0] pix_fmt;
  logic        tuser_in, tlast_in;

  logic [33:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [33:0] rd_word;

  assign vs_fall   = vsync_q & ~vsync;
  assign bus_on    = (state_q != WAIT_VS) && !vsync;
  assign pix_done  = bus_on && href && phase_q;
  assign href_fall = bus_on && href_q && !href;
  assign in_bounds = (col_q < H_LIM) && (row_q < V_LIM);
  assign pixel     = {hi_q, data};
  assign tuser_in  = (col_q == 12'd0) && (row_q == 12'd0);
  assign tlast_in  = (col_q == H_LAST);

  // RGB565 -> RGB888 by replicating the top bits of each channel into the low bits
  always_comb begin
    pix_fmt = '0;
    if (OUT_FMT == 1)
      pix_fmt = {16'h0000, pixel};
    else
      pix_fmt = {8'h00,
                 pixel[15:11], pixel[15:13],
                 pixel[10:5],  pixel[10:9],
                 pixel[4:0],   pixel[4:2]};
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state_q <= WAIT_VS;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      WAIT_VS: if (vs_fall) state_d = CAPTURE;
      CAPTURE: begin
        if (pix_done && in_bounds) begin
          // a pop on the same edge frees the slot, so the push still lands
          if (!full || pop) begin
            push = 1'b1;
          end else begin
            ovf_set = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP:    if (vs_fall) state_d = CAPTURE;
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
      col_q   <= 12'd0;
      row_q   <= 12'd0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      if (!bus_on) begin
        phase_q <= 1'b0;
        col_q   <= 12'd0;
        row_q   <= 12'd0;
      end else begin
        phase_q <= href ? ~phase_q : 1'b0;
        if (href && !phase_q) hi_q <= data;
        // counters saturate so an overlong line can never wrap back into bounds
        if (href_fall) begin
          col_q <= 12'd0;
          if (col_q != 12'd0 && row_q != 12'hFFF) row_q <= row_q + 12'd1;
        end else if (pix_done && col_q != 12'hFFF) begin
          col_q <= col_q + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
  end

  assign frame_active = (state_q == CAPTURE);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && m_axis.tready;

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {pix_fmt, tlast_in, tuser_in};
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // head entry is masked while empty so the bus reads zero out of reset
  assign rd_word       = mem[rd_ptr[AW-1:0]];
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = empty ? 32'h0 : rd_word[33:2];
  assign m_axis.tlast  = !empty && rd_word[1];
  assign m_axis.tuser  = !empty && rd_word[0];

`ifdef CAM_CAPTURE_STATS_EN
  logic vs_rise, line_err;

  assign vs_rise  = ~vsync_q & vsync;
  assign line_err = href_fall && (col_q != 12'd0) && (col_q < H_LIM);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_count    <= 16'h0000;
      line_err_count <= 16'h0000;
    end else begin
      if (vs_rise && state_q != WAIT_VS) frame_count <= frame_count + 16'd1;
      if (line_err && line_err_count != 16'hFFFF) line_err_count <= line_err_count + 16'd1;
    end
  end
`else
  assign frame_count    = 16'h0000;
  assign line_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cam_capture_axis.sv
// Directed bench for cam_capture_axis: 4x2 frames into an RGB888 and an RGB565 instance.
module tb_cam_capture_axis;

`ifdef CAM_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [15:0] pix;
    logic [31:0] e888;
    logic [31:0] e565;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } beat_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic        href;
  logic        vsync;
  logic [7:0]  data;
  logic        overflow0, overflow1, frame_active0, frame_active1;
  logic [15:0] frame_count0, frame_count1, line_err0, line_err1;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t q0[$];
  beat_t q1[$];
  vec_t  vecs[7];

  cam_capture_axis_if axis0();
  cam_capture_axis_if axis1();

  assign axis1.tready = 1'b1;

  cam_capture_axis #(.H_ACTIVE(4), .V_ACTIVE(2), .FIFO_DEPTH(4), .OUT_FMT(0)) dut0 (
    .pclk(pclk), .rst(rst), .href(href), .vsync(vsync), .data(data),
    .m_axis(axis0), .overflow(overflow0), .frame_active(frame_active0),
    .frame_count(frame_count0), .line_err_count(line_err0));

  cam_capture_axis #(.H_ACTIVE(4), .V_ACTIVE(2), .FIFO_DEPTH(4), .OUT_FMT(1)) dut1 (
    .pclk(pclk), .rst(rst), .href(href), .vsync(vsync), .data(data),
    .m_axis(axis1), .overflow(overflow1), .frame_active(frame_active1),
    .frame_count(frame_count1), .line_err_count(line_err1));

  always #5 pclk = ~pclk;

  // inputs change on the falling edge; accepted beats are recorded 2 ns later
  always begin
    @(negedge pclk);
    #2;
    if (axis0.tvalid && axis0.tready) q0.push_back({axis0.tdata, axis0.tlast, axis0.tuser});
    if (axis1.tvalid && axis1.tready) q1.push_back({axis1.tdata, axis1.tlast, axis1.tuser});
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(3);
  endtask

  task automatic send_line(input int n, input logic [15:0] pix);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      data = pix[15:8];
      @(negedge pclk);
      data = pix[7:0];
      @(negedge pclk);
    end
    href = 1'b0;
    data = 8'h00;
    idle(3);
  endtask

  task automatic expect_line(input string tag, input int n, input logic [31:0] d0,
                             input logic [31:0] d1, input logic first_user,
                             input logic has_last, input bit use1);
    int    waited;
    beat_t b;
    waited = 0;
    while ((q0.size() < n || (use1 && q1.size() < n)) && waited < 300) begin
      @(negedge pclk);
      waited++;
    end
    chk({tag, " beats rgb888"}, 32'((q0.size() < n) ? q0.size() : n), 32'(n));
    if (use1) chk({tag, " beats rgb565"}, 32'((q1.size() < n) ? q1.size() : n), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (q0.size() > 0) begin
        b = q0.pop_front();
        chk($sformatf("%s[%0d] tdata888", tag, i), b.d, d0);
        chk($sformatf("%s[%0d] tuser", tag, i), 32'(b.u), 32'(first_user && (i == 0)));
        chk($sformatf("%s[%0d] tlast", tag, i), 32'(b.l), 32'(has_last && (i == n - 1)));
      end
      if (use1 && q1.size() > 0) begin
        b = q1.pop_front();
        chk($sformatf("%s[%0d] tdata565", tag, i), b.d, d1);
      end
    end
  endtask

  initial begin
    // G6 of 16'h0841 is 6'd2, so every channel expands to 8'h08
    vecs[0] = '{16'hF800, 32'h00FF0000, 32'h0000F800};
    vecs[1] = '{16'h07E0, 32'h0000FF00, 32'h000007E0};
    vecs[2] = '{16'h0841, 32'h00080808, 32'h00000841};
    vecs[3] = '{16'h001F, 32'h000000FF, 32'h0000001F};
    vecs[4] = '{16'hFFFF, 32'h00FFFFFF, 32'h0000FFFF};
    vecs[5] = '{16'h0000, 32'h00000000, 32'h00000000};
    vecs[6] = '{16'hA5A5, 32'h00A5B629, 32'h0000A5A5};

    rst = 1'b1;
    href = 1'b0;
    vsync = 1'b0;
    data = 8'h00;
    axis0.tready = 1'b1;
    idle(3);
    chk("reset tvalid", 32'(axis0.tvalid), 32'd0);
    chk("reset tlast", 32'(axis0.tlast), 32'd0);
    chk("reset tuser", 32'(axis0.tuser), 32'd0);
    chk("reset tdata", axis0.tdata, 32'h0);
    chk("reset overflow", 32'(overflow0), 32'd0);
    chk("reset frame_active", 32'(frame_active0), 32'd0);
    chk("reset frame_count", 32'(frame_count0), 32'd0);
    chk("reset line_err_count", 32'(line_err0), 32'd0);
    rst = 1'b0;
    idle(2);

    // bus activity before any vsync must be ignored
    send_line(4, 16'hF800);
    idle(10);
    chk("pre-vsync beats rgb888", 32'(q0.size()), 32'd0);
    chk("pre-vsync beats rgb565", 32'(q1.size()), 32'd0);
    chk("pre-vsync frame_active", 32'(frame_active0), 32'd0);

    vs_pulse();
    chk("capture frame_active", 32'(frame_active0), 32'd1);
    send_line(4, 16'hF800);
    send_line(4, 16'hF800);
    expect_line("frame row0", 4, 32'h00FF0000, 32'h0000F800, 1'b1, 1'b1, 1'b1);
    expect_line("frame row1", 4, 32'h00FF0000, 32'h0000F800, 1'b0, 1'b1, 1'b1);

    for (int v = 0; v < 7; v++) begin
      vs_pulse();
      send_line(4, vecs[v].pix);
      expect_line($sformatf("vec%0d", v), 4, vecs[v].e888, vecs[v].e565, 1'b1, 1'b1, 1'b1);
    end

    // overlong line is clipped at H_ACTIVE, then a short line carries no TLAST
    vs_pulse();
    send_line(6, 16'h001F);
    expect_line("long line", 4, 32'h000000FF, 32'h0000001F, 1'b1, 1'b1, 1'b1);
    idle(6);
    chk("long line extra beats", 32'(q0.size()), 32'd0);
    send_line(3, 16'h07E0);
    expect_line("short line", 3, 32'h0000FF00, 32'h000007E0, 1'b0, 1'b0, 1'b1);
    chk("short line line_err_count", 32'(line_err0), STATS ? 32'd1 : 32'd0);

    // stalled sink: 4 beats fit, the 5th pixel overflows and the frame is dropped
    axis0.tready = 1'b0;
    vs_pulse();
    send_line(4, 16'h001F);
    send_line(4, 16'h001F);
    idle(4);
    chk("stall overflow", 32'(overflow0), 32'd1);
    chk("stall frame_active", 32'(frame_active0), 32'd0);
    chk("stall tvalid", 32'(axis0.tvalid), 32'd1);
    chk("stall tdata held", axis0.tdata, 32'h000000FF);
    chk("stall tuser held", 32'(axis0.tuser), 32'd1);
    chk("stall beats taken", 32'(q0.size()), 32'd0);
    chk("stall rgb565 overflow", 32'(overflow1), 32'd0);
    q1.delete();
    axis0.tready = 1'b1;
    expect_line("stale", 4, 32'h000000FF, 32'h0, 1'b1, 1'b1, 1'b0);
    vs_pulse();
    chk("resume frame_active", 32'(frame_active0), 32'd1);
    send_line(4, 16'h07E0);
    send_line(4, 16'h07E0);
    expect_line("resume row0", 4, 32'h0000FF00, 32'h000007E0, 1'b1, 1'b1, 1'b1);
    expect_line("resume row1", 4, 32'h0000FF00, 32'h000007E0, 1'b0, 1'b1, 1'b1);
    chk("overflow sticky", 32'(overflow0), 32'd1);

    // reset in the middle of a line, with beats waiting in the FIFO
    axis0.tready = 1'b0;
    vs_pulse();
    for (int i = 0; i < 2; i++) begin
      href = 1'b1;
      data = 8'h12;
      @(negedge pclk);
      data = 8'h34;
      @(negedge pclk);
    end
    chk("pre-rst tvalid", 32'(axis0.tvalid), 32'd1);
    q1.delete();
    rst = 1'b1;
    #1;
    chk("mid-line rst tvalid", 32'(axis0.tvalid), 32'd0);
    chk("mid-line rst overflow", 32'(overflow0), 32'd0);
    chk("mid-line rst frame_active", 32'(frame_active0), 32'd0);
    @(negedge pclk);
    rst = 1'b0;
    axis0.tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data = 8'h12;
      @(negedge pclk);
      data = 8'h34;
      @(negedge pclk);
    end
    href = 1'b0;
    idle(3);
    send_line(4, 16'hF800);
    send_line(4, 16'hF800);
    idle(6);
    chk("post-rst beats rgb888", 32'(q0.size()), 32'd0);
    chk("post-rst beats rgb565", 32'(q1.size()), 32'd0);
    chk("post-rst frame_count", 32'(frame_count0), 32'd0);

    // three complete frames bracketed by vsync pulses
    for (int f = 0; f < 3; f++) begin
      vs_pulse();
      send_line(4, 16'hF800);
      send_line(4, 16'hF800);
    end
    vs_pulse();
    idle(4);
    chk("three frames beats", 32'(q0.size()), 32'd24);
    chk("three frames frame_count", 32'(frame_count0), STATS ? 32'd3 : 32'd0);
    chk("three frames line_err_count", 32'(line_err0), 32'd0);
    q0.delete();
    q1.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
